// File: rtl/pwl_table_writer.sv
// Unpacks framed config words into PWL table RAM writes and bias writes; writes land 1 cycle after acceptance.
// Stalls only in FIN; optional trailing XOR checksum beat under `PWL_TABLE_WRITER_CHECKSUM_EN.
module pwl_table_writer #(
  parameter int n_settings    = 4,
  parameter int setting_width = 2,
  parameter int addr_width    = 8,
  parameter int offset_width  = 18,
  parameter int slope_width   = 18,
  parameter int bias_width    = 32,
  parameter int word_width    = 36
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [word_width-1:0]               s_data,
  input  logic                                s_last,
  output logic                                wr_en,
  output logic [setting_width+addr_width-1:0] wr_addr,
  output logic [offset_width+slope_width-1:0] wr_data,
  output logic                                bias_wr_en,
  output logic [setting_width-1:0]            bias_wr_setting,
  output logic [bias_width-1:0]               bias_wr_val,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  localparam int dw = offset_width + slope_width;
  localparam logic [addr_width-1:0]    idx_max  = '1;
  localparam logic [setting_width:0]   nset_ext = n_settings[setting_width:0];

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    BIAS,
    DRAIN,
    FIN
`ifdef PWL_TABLE_WRITER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [setting_width-1:0] setting_q, setting_d;
  logic [addr_width-1:0]   idx_q, idx_d;
  logic                    err_d;
  logic                    alive_q;
  logic                    accept;
  logic                    wr_en_d;
  logic                    bias_en_d;
  logic [bias_width-1:0]   bias_src;
`ifdef PWL_TABLE_WRITER_CHECKSUM_EN
  logic [word_width-1:0]   csum_q, csum_d;
  logic [bias_width-1:0]   bias_hold_q, bias_hold_d;
`endif

  // alive_q keeps s_ready low through reset and for the first edge after release
  assign s_ready = alive_q && (state_q != FIN);
  assign accept  = s_valid && s_ready;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);

  always_comb begin
    state_d   = state_q;
    setting_d = setting_q;
    idx_d     = idx_q;
    err_d     = err;
    wr_en_d   = 1'b0;
    bias_en_d = 1'b0;
    bias_src  = s_data[bias_width-1:0];
`ifdef PWL_TABLE_WRITER_CHECKSUM_EN
    csum_d      = csum_q;
    bias_hold_d = bias_hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          setting_d = s_data[setting_width-1:0];
          idx_d     = '0;
          err_d     = 1'b0;
`ifdef PWL_TABLE_WRITER_CHECKSUM_EN
          csum_d    = s_data;
`endif
          if (s_last) begin
            err_d = 1'b1;
          end else if ({1'b0, s_data[setting_width-1:0]} >= nset_ext) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = ENTRY;
          end
        end
      end
      ENTRY: begin
        if (accept) begin
          wr_en_d = 1'b1;
          idx_d   = idx_q + 1'b1;
`ifdef PWL_TABLE_WRITER_CHECKSUM_EN
          csum_d  = csum_q ^ s_data;
`endif
          if (s_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (idx_q == idx_max) begin
            state_d = BIAS;
          end
        end
      end
      BIAS: begin
        if (accept) begin
`ifdef PWL_TABLE_WRITER_CHECKSUM_EN
          csum_d      = csum_q ^ s_data;
          bias_hold_d = s_data[bias_width-1:0];
          if (s_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = CHK;
          end
`else
          if (s_last) begin
            bias_en_d = 1'b1;
            state_d   = FIN;
          end else begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
`endif
        end
      end
`ifdef PWL_TABLE_WRITER_CHECKSUM_EN
      CHK: begin
        bias_src = bias_hold_q;
        if (accept) begin
          if (!s_last) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else if (s_data == csum_q) begin
            bias_en_d = 1'b1;
            state_d   = FIN;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      DRAIN: begin
        if (accept && s_last) state_d = IDLE;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      setting_q <= '0;
      idx_q     <= '0;
      err       <= 1'b0;
      alive_q   <= 1'b0;
`ifdef PWL_TABLE_WRITER_CHECKSUM_EN
      csum_q      <= '0;
      bias_hold_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      setting_q <= setting_d;
      idx_q     <= idx_d;
      err       <= err_d;
      alive_q   <= 1'b1;
`ifdef PWL_TABLE_WRITER_CHECKSUM_EN
      csum_q      <= csum_d;
      bias_hold_q <= bias_hold_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en           <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= '0;
      bias_wr_en      <= 1'b0;
      bias_wr_setting <= '0;
      bias_wr_val     <= '0;
    end else begin
      wr_en      <= wr_en_d;
      bias_wr_en <= bias_en_d;
      if (wr_en_d) begin
        wr_addr <= {setting_q, idx_q};
        wr_data <= s_data[dw-1:0];
      end
      if (bias_en_d) begin
        bias_wr_setting <= setting_q;
        bias_wr_val     <= bias_src;
      end
    end
  end

endmodule
